spi_bus_arbiter: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_arb_pinmux.sv | 46 ++++
 rtl/spi_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the two-requester SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  // Requester IDs as stored in last_served.
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // Cycle-count parameters of zero behave as one.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/spi_arb_pinmux.sv
// Pin and MISO steering for the shared SPI bus, selected by the registered arbiter state.
module spi_arb_pinmux
  import spi_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       m0_sclk,
  input  logic       m0_mosi,
  input  logic       m0_cs_n,
  input  logic       m1_sclk,
  input  logic       m1_mosi,
  input  logic       m1_cs_n,
  input  logic       spi_miso,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_cs1,
  output logic       spi_cs2,
  output logic       m0_miso,
  output logic       m1_miso
);

  // Owner drives the pins; everyone else is masked to an idle bus.
  always_comb begin
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs1  = 1'b1;
    spi_cs2  = 1'b1;
    m0_miso  = 1'b0;
    m1_miso  = 1'b0;
    case (state)
      GNT0: begin
        spi_clk  = m0_sclk;
        spi_mosi = m0_mosi;
        spi_cs1  = m0_cs_n;
        m0_miso  = spi_miso;
      end
      GNT1: begin
        spi_clk  = m1_sclk;
        spi_mosi = m1_mosi;
        spi_cs2  = m1_cs_n;
        m1_miso  = spi_miso;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the single SPI pin set between two engines, one whole transaction
// per grant, with a chip-select deassert gap between owners.
// Optional grant timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter bit          RR             = 1'b1,
  parameter int unsigned CS_GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  output logic gnt0,
  input  logic m0_sclk,
  input  logic m0_mosi,
  input  logic m0_cs_n,
  output logic m0_miso,
  input  logic req1,
  output logic gnt1,
  input  logic m1_sclk,
  input  logic m1_mosi,
  input  logic m1_cs_n,
  output logic m1_miso,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic spi_cs1,
  output logic spi_cs2,
  output logic busy,
  output logic timeout_err
);

  localparam int unsigned GAP_N = at_least_one(CS_GAP_CYCLES);
  localparam int unsigned GAP_W = $clog2(GAP_N) + 1;

  arb_state_t       state, state_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             last_served, last_served_n;
  logic             req0_eff_c, req1_eff_c;
  logic             tmo_hit_c;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_N = at_least_one(TIMEOUT_CYCLES);
  localparam int unsigned TMO_W = $clog2(TMO_N) + 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             stale0, stale1;

  // Grant overrun: owner still requesting when the grant budget is spent.
  always_comb begin
    tmo_hit_c = (((state == GNT0) && req0) || ((state == GNT1) && req1)) &&
                (tmo_cnt == TMO_W'(TMO_N - 1));
  end

  assign req0_eff_c = req0 & ~stale0;
  assign req1_eff_c = req1 & ~stale1;

  // Grant length counter, stale-requester flags and the timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      stale0      <= 1'b0;
      stale1      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == GNT0 || state == GNT1) && (state_n == state))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      else
        tmo_cnt <= '0;
      stale0      <= (tmo_hit_c && (state == GNT0)) | (stale0 & req0);
      stale1      <= (tmo_hit_c && (state == GNT1)) | (stale1 & req1);
      timeout_err <= tmo_hit_c;
    end
  end
`else
  logic unused_timeout_cfg;

  assign req0_eff_c         = req0;
  assign req1_eff_c         = req1;
  assign tmo_hit_c          = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic: grant selection in IDLE, release/timeout in GNTx, gap count.
  always_comb begin
    state_n       = state;
    gap_cnt_n     = gap_cnt;
    last_served_n = last_served;
    case (state)
      IDLE: begin
        gap_cnt_n = '0;
        if (req0_eff_c && req1_eff_c)
          state_n = (RR && (last_served == REQ_ID0)) ? GNT1 : GNT0;
        else if (req0_eff_c)
          state_n = GNT0;
        else if (req1_eff_c)
          state_n = GNT1;
      end
      GNT0: begin
        last_served_n = REQ_ID0;
        if (!req0 || tmo_hit_c) begin
          state_n   = GAP;
          gap_cnt_n = '0;
        end
      end
      GNT1: begin
        last_served_n = REQ_ID1;
        if (!req1 || tmo_hit_c) begin
          state_n   = GAP;
          gap_cnt_n = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_N - 1))
          state_n = IDLE;
        else
          gap_cnt_n = gap_cnt + GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered grant/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      last_served <= REQ_ID1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      gap_cnt     <= gap_cnt_n;
      last_served <= last_served_n;
      gnt0        <= (state_n == GNT0);
      gnt1        <= (state_n == GNT1);
      busy        <= (state_n != IDLE);
    end
  end

  spi_arb_pinmux u_pinmux (
    .state    (state),
    .m0_sclk  (m0_sclk),
    .m0_mosi  (m0_mosi),
    .m0_cs_n  (m0_cs_n),
    .m1_sclk  (m1_sclk),
    .m1_mosi  (m1_mosi),
    .m1_cs_n  (m1_cs_n),
    .spi_miso (spi_miso),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_cs1  (spi_cs1),
    .spi_cs2  (spi_cs2),
    .m0_miso  (m0_miso),
    .m1_miso  (m1_miso)
  );

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: round-robin instance plus a fixed-priority instance.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic req0, req1, m0_sclk, m0_mosi, m0_cs_n, m1_sclk, m1_mosi, m1_cs_n, spi_miso;
  logic gnt0, gnt1, m0_miso, m1_miso, spi_clk, spi_mosi, spi_cs1, spi_cs2, busy, timeout_err;
  logic fp_req0, fp_req1;
  logic fp_gnt0, fp_gnt1, fp_m0_miso, fp_m1_miso, fp_spi_clk, fp_spi_mosi;
  logic fp_spi_cs1, fp_spi_cs2, fp_busy, fp_timeout_err;

  spi_bus_arbiter #(.RR(1'b1), .CS_GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .gnt0(gnt0), .m0_sclk(m0_sclk), .m0_mosi(m0_mosi), .m0_cs_n(m0_cs_n), .m0_miso(m0_miso),
    .req1(req1), .gnt1(gnt1), .m1_sclk(m1_sclk), .m1_mosi(m1_mosi), .m1_cs_n(m1_cs_n), .m1_miso(m1_miso),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs1(spi_cs1), .spi_cs2(spi_cs2),
    .busy(busy), .timeout_err(timeout_err)
  );

  spi_bus_arbiter #(.RR(1'b0), .CS_GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(fp_req0), .gnt0(fp_gnt0), .m0_sclk(m0_sclk), .m0_mosi(m0_mosi), .m0_cs_n(m0_cs_n), .m0_miso(fp_m0_miso),
    .req1(fp_req1), .gnt1(fp_gnt1), .m1_sclk(m1_sclk), .m1_mosi(m1_mosi), .m1_cs_n(m1_cs_n), .m1_miso(fp_m1_miso),
    .spi_clk(fp_spi_clk), .spi_mosi(fp_spi_mosi), .spi_miso(spi_miso), .spi_cs1(fp_spi_cs1), .spi_cs2(fp_spi_cs2),
    .busy(fp_busy), .timeout_err(fp_timeout_err)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HOLD = 10;
`else
  localparam int HOLD = 20;
`endif

  // owner: 0 idle, 1 granted to m0, 2 granted to m1
  // m0/m1: {sclk, mosi, cs_n}; exp: {spi_clk, spi_mosi, spi_cs1, spi_cs2, m0_miso, m1_miso}
  typedef struct {
    logic [1:0] owner;
    logic [2:0] m0;
    logic [2:0] m1;
    logic       miso;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input bit fp_sel, input logic a, input logic b);
    if (fp_sel) begin fp_req0 = a; fp_req1 = b; end
    else begin req0 = a; req1 = b; end
  endtask

  task automatic idle_pins();
    {m0_sclk, m0_mosi, m0_cs_n} = 3'b001;
    {m1_sclk, m1_mosi, m1_cs_n} = 3'b001;
  endtask

  task automatic wait_idle(input bit fp_sel);
    for (int i = 0; i < 20; i++) begin
      if (!(fp_sel ? fp_busy : busy)) break;
      tick();
    end
    chk("wait_idle", 8'(fp_sel ? fp_busy : busy), 8'd0);
  endtask

  task automatic wait_gnt(input bit fp_sel, output int id);
    id = -1;
    for (int i = 0; i < 30; i++) begin
      if (fp_sel ? fp_gnt0 : gnt0) begin id = 0; break; end
      if (fp_sel ? fp_gnt1 : gnt1) begin id = 1; break; end
      tick();
    end
  endtask

  task automatic goto_owner(input logic [1:0] o);
    set_reqs(1'b0, 1'b0, 1'b0);
    idle_pins();
    wait_idle(1'b0);
    if (o != 2'd0) begin
      if (o == 2'd1) req0 = 1'b1; else req1 = 1'b1;
      chk("gnt_not_early", 8'({gnt0, gnt1}), 8'd0);
      tick();
      chk("gnt_one_cycle", 8'({gnt0, gnt1}), (o == 2'd1) ? 8'd2 : 8'd1);
    end
  endtask

  // Contention: both requesters re-request right after each release.
  task automatic run_order(input bit fp_sel, input int n);
    int id, e;
    set_reqs(fp_sel, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      wait_gnt(fp_sel, id);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
      chk(fp_sel ? "fp_order" : "rr_order", 8'(id), 8'(e));
      repeat (3) tick();
      if (id == 1) set_reqs(fp_sel, 1'b1, 1'b0);
      else set_reqs(fp_sel, 1'b0, 1'b1);
      tick();
      set_reqs(fp_sel, 1'b1, 1'b1);
    end
    set_reqs(fp_sel, 1'b0, 1'b0);
    wait_idle(fp_sel);
  endtask

  // The chip-selects of one bus must never be low together.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((!spi_cs1 && !spi_cs2) || (!fp_spi_cs1 && !fp_spi_cs2))) begin
      checks++;
      errors++;
      $display("FAIL cs_overlap: cs1=%b cs2=%b fp_cs1=%b fp_cs2=%b required not both low at %0t",
               spi_cs1, spi_cs2, fp_spi_cs1, fp_spi_cs2, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int id, lat, hi, seen;
    vecs[0] = '{2'd0, 3'b110, 3'b110, 1'b1, 6'b001100};
    vecs[1] = '{2'd0, 3'b000, 3'b000, 1'b1, 6'b001100};
    vecs[2] = '{2'd1, 3'b001, 3'b110, 1'b1, 6'b001110};
    vecs[3] = '{2'd1, 3'b000, 3'b000, 1'b1, 6'b000110};
    vecs[4] = '{2'd1, 3'b110, 3'b001, 1'b0, 6'b110100};
    vecs[5] = '{2'd1, 3'b100, 3'b111, 1'b1, 6'b100110};
    vecs[6] = '{2'd2, 3'b110, 3'b000, 1'b1, 6'b001001};
    vecs[7] = '{2'd2, 3'b000, 3'b110, 1'b0, 6'b111000};
    vecs[8] = '{2'd2, 3'b000, 3'b101, 1'b1, 6'b101101};
    vecs[9] = '{2'd2, 3'b111, 3'b011, 1'b1, 6'b011101};

    set_reqs(1'b0, 1'b0, 1'b0);
    set_reqs(1'b1, 1'b0, 1'b0);
    idle_pins();
    spi_miso = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 8'({gnt0, gnt1, fp_gnt0, fp_gnt1}), 8'd0);
    chk("rst_busy_tmo", 8'({busy, timeout_err, fp_busy, fp_timeout_err}), 8'd0);
    chk("rst_pins", 8'({spi_clk, spi_mosi, spi_cs1, spi_cs2, m0_miso, m1_miso}), 8'b001100);
    spi_miso = 1'b1;
    #1 chk("rst_miso", 8'({m0_miso, m1_miso, fp_m0_miso, fp_m1_miso}), 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();

    // Pin-mux vectors in IDLE, GNT0 and GNT1.
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || vecs[i].owner != vecs[(i == 0) ? 0 : i - 1].owner) goto_owner(vecs[i].owner);
      {m0_sclk, m0_mosi, m0_cs_n} = vecs[i].m0;
      {m1_sclk, m1_mosi, m1_cs_n} = vecs[i].m1;
      spi_miso = vecs[i].miso;
      #1;
      chk($sformatf("pinmux[%0d]", i), 8'({spi_clk, spi_mosi, spi_cs1, spi_cs2, m0_miso, m1_miso}), 8'(vecs[i].exp));
    end
    goto_owner(2'd0);

    // Long grant, release, then a gap of exactly two cycles.
    req0 = 1'b1;
    tick();
    repeat (HOLD - 1) tick();
    chk("long_grant", 8'({gnt0, timeout_err}), 8'b10);
    req0 = 1'b0;
    tick();
    chk("release", 8'({gnt0, spi_cs1, spi_cs2, busy}), 8'b0111);
    tick();
    chk("gap_second", 8'({busy, spi_cs1, spi_cs2}), 8'b111);
    tick();
    chk("gap_end", 8'(busy), 8'd0);

    // Request from requester 1 during GNT0 waits for the gap.
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= int'(gnt1); end
    chk("gnt1_early", 8'(seen), 8'd0);
    req0 = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin tick(); lat++; if (gnt1) break; end
    chk("regrant_latency", 8'(lat), 8'd4);
    req1 = 1'b0;
    wait_idle(1'b0);

    // One-cycle request pulse still yields a one-cycle grant.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk("pulse_gnt", 8'(gnt1), 8'd1);
    tick();
    chk("pulse_release", 8'({gnt1, busy}), 8'b01);
    wait_idle(1'b0);

    // Asynchronous reset in the middle of a transaction.
    req0 = 1'b1;
    tick();
    m0_cs_n = 1'b0;
    #1 chk("cs1_follow", 8'({spi_cs1, spi_cs2}), 8'b01);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 8'({spi_cs1, gnt0, busy}), 8'b100);
    m0_cs_n = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Arbitration order under continuous contention.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    run_order(1'b0, 4);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    run_order(1'b1, 4);

`ifdef SPI_ARB_TIMEOUT_EN
    // Stuck requester 0 is cut off, requester 1 is served, requester 0 stays blocked.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin if (!gnt0) break; hi++; tick(); end
    chk("tmo_len", 8'(hi), 8'd16);
    chk("tmo_pulse", 8'({timeout_err, gnt0}), 8'b10);
    tick();
    chk("tmo_one_cycle", 8'(timeout_err), 8'd0);
    exp_q.push_back(1);
    wait_gnt(1'b0, id);
    chk("tmo_next_owner", 8'(id), 8'(exp_q.pop_front()));
    req1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); seen |= int'(gnt0); end
    chk("stale_block", 8'(seen), 8'd0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    exp_q.push_back(0);
    wait_gnt(1'b0, id);
    chk("stale_clear", 8'(id), 8'(exp_q.pop_front()));
    req0 = 1'b0;
    wait_idle(1'b0);
`else
    // Without the timeout a grant lasts as long as the request.
    req0 = 1'b1;
    repeat (40) tick();
    chk("no_timeout", 8'({gnt0, timeout_err}), 8'b10);
    req0 = 1'b0;
    wait_idle(1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
